// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU constants, state encoding and helpers
//
// Purpose: common definitions for the iterative divider and the reciprocal
//          datapath (fdiv_iter, finv_seed_rom, and sibling finv/fmul units).
// Ports:   none (package).

package fpu_pkg;

   localparam int FRAC_W = 32;              // reciprocal iterate width, 1.31 fixed point
   localparam int SEED_W = 8;               // seed ROM index/data width
   localparam int BIAS   = 127;             // single-precision exponent bias

   localparam logic [7:0]  EXP_INF  = 8'hff;
   localparam logic [30:0] INF_MAG  = 31'h7f80_0000;
   localparam logic [30:0] ZERO_MAG = 31'h0000_0000;

   typedef enum logic [3:0] {
      S_IDLE,
      S_SEED,
      S_NR1M,
      S_NR1S,
      S_NR2M,
      S_NR2S,
      S_QMUL,
      S_REM,
      S_RND,
      S_DONE
   } fdiv_state_e;

   // Significand with the hidden bit restored (normal operands only).
   function automatic logic [23:0] mant_of(input logic [31:0] f);
      return {1'b1, f[22:0]};
   endfunction

endpackage

// File: rtl/fdiv_iter_if.sv
// rtl/fdiv_iter_if.sv - issue/result handshake bundle of the iterative divider
//
// Purpose: groups the operand (in_*) and result (out_*) handshakes.
// Signals: in_valid/in_ready/a/b      operand channel (master -> slave)
//          out_valid/out_ready/d      result channel  (slave -> master)
//          overflow/underflow         result flags, qualified by out_valid
// Modports: master = issue stage / consumer, slave = divider.

interface fdiv_iter_if;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] d;
   logic        overflow;
   logic        underflow;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, d, overflow, underflow
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, d, overflow, underflow
   );

endinterface

// File: rtl/finv_seed_rom.sv
// rtl/finv_seed_rom.sv - reciprocal seed table
//
// Purpose: combinational 256x8 ROM. Entry i holds the top fraction bits of
//          2/(1+(i+0.5)/256), i.e. the reciprocal of the bucket midpoint of
//          b_m/2, so {1, rom[i]} is a 1.8 estimate of 2/b_m.
// Ports:   idx_i   in   SEED_W  top mantissa bits of the divisor
//          seed_o  out  SEED_W  fraction bits of the seed

module finv_seed_rom
   import fpu_pkg::*;
(
   input  logic [SEED_W-1:0] idx_i,
   output logic [SEED_W-1:0] seed_o
);

   logic [SEED_W-1:0] rom [2**SEED_W];

   // frac(2N/(N+i+0.5)) * N == 4N^2/(2N+2i+1) - N, computed at elaboration.
   for (genvar g = 0; g < 2**SEED_W; g++) begin : g_rom
      localparam int VAL = (1 << (2*SEED_W + 2)) / ((1 << (SEED_W + 1)) + 2*g + 1)
                           - (1 << SEED_W);
      assign rom[g] = SEED_W'(VAL);
   end

   assign seed_o = rom[idx_i];

endmodule

// File: rtl/fdiv_iter.sv
// rtl/fdiv_iter.sv - multi-cycle IEEE single-precision divider d = a / b
//
// Purpose: seed 1/b from a table, refine with two Newton-Raphson steps on one
//          shared 32x32 multiplier, form q = a * (1/b), fix q with an exact
//          remainder and round to nearest even. Fixed 8-cycle latency.
// Ports:   clk        in   clock, rising edge
//          rstn       in   asynchronous active-low reset
//          bus.slave  operand/result handshakes and flags (fdiv_iter_if)
//
// Fixed-point map: b' = b_m/2 in [0.5,1) as 0.32, x ~ 1/b' in 1.31, so
// q = 2*a_m*x ~ a_m*2^25/b_m (26 bits, 2 or 1 extra bits below the result LSB).

module fdiv_iter
   import fpu_pkg::*;
(
   input  logic      clk,
   input  logic      rstn,
   fdiv_iter_if.slave bus
);

   fdiv_state_e       state_q, state_d;
   logic [31:0]       a_q, a_d, b_q, b_d;
   logic [FRAC_W-1:0] x_q, x_d, t_q, t_d;
   logic [25:0]       q_q, q_d;
   logic              sticky_q, sticky_d;
   logic              sp_q, sp_d, sp_inf_q, sp_inf_d;
   logic [31:0]       d_q, d_d;
   logic              ovf_q, ovf_d, unf_q, unf_d;

   logic [23:0] a_m, b_m;
   logic        sign;
   logic [7:0]  a_exp, b_exp;

   assign a_m   = mant_of(a_q);
   assign b_m   = mant_of(b_q);
   assign sign  = a_q[31] ^ b_q[31];
   assign a_exp = a_q[30:23];
   assign b_exp = b_q[30:23];

   // ---------------- seed table ----------------
   logic [SEED_W-1:0] seed;

   finv_seed_rom u_seed_rom (
      .idx_i  (b_q[22 -: SEED_W]),
      .seed_o (seed)
   );

   // ---------------- shared multiplier ----------------
   logic [31:0] mul_a, mul_b;
   logic [63:0] prod;

   always_comb begin
      mul_a = '0;
      mul_b = '0;
      unique case (state_q)
         S_NR1M, S_NR2M: begin
            mul_a = {b_m, 8'h00};          // b' as 0.32
            mul_b = x_q;
         end
         S_NR1S, S_NR2S: begin
            mul_a = x_q;
            mul_b = 32'd0 - t_q;           // 2 - t in 1.31 (t is never 0)
         end
         S_QMUL: begin
            mul_a = {8'h00, a_m};
            mul_b = x_q;
         end
         S_REM: begin
            mul_a = {6'd0, q_q};
            mul_b = {8'h00, b_m};
         end
         default: ;
      endcase
   end

   assign prod = {32'd0, mul_a} * {32'd0, mul_b};

   // ---------------- remainder correction ----------------
   // The estimate is within one of floor(a_m*2^25/b_m); one step either way fixes it.
   logic signed [50:0] r_raw, r_fix, b_ext;
   logic        [25:0] q_fix;

   always_comb begin
      b_ext = $signed({27'd0, b_m});
      r_raw = $signed({2'b00, a_m, 25'd0}) - $signed({1'b0, prod[49:0]});
      q_fix = q_q;
      r_fix = r_raw;
      if (r_raw[50]) begin
         q_fix = q_q - 26'd1;
         r_fix = r_raw + b_ext;
      end else if (r_raw >= b_ext) begin
         q_fix = q_q + 26'd1;
         r_fix = r_raw - b_ext;
      end
   end

   // ---------------- rounding ----------------
   // q[25] set means a_m >= b_m: result LSB at q[2], else at q[1] and exponent - 1.
   logic [23:0] mant;
   logic [24:0] mant_r;
   logic        guard, stk, rnd_up, norm_dec;
   logic [9:0]  e_r;
   logic [22:0] frac_r;

   always_comb begin
      if (q_q[25]) begin
         mant     = q_q[25:2];
         guard    = q_q[1];
         stk      = q_q[0] | sticky_q;
         norm_dec = 1'b0;
      end else begin
         mant     = q_q[24:1];
         guard    = q_q[0];
         stk      = sticky_q;
         norm_dec = 1'b1;
      end
      rnd_up = guard & (stk | mant[0]);
      mant_r = {1'b0, mant} + {24'd0, rnd_up};
      e_r    = {2'b00, a_exp} - {2'b00, b_exp} + 10'(BIAS)
               - {9'd0, norm_dec} + {9'd0, mant_r[24]};
      // On carry-out mant_r is exactly 2^24, so [23:1] is all zero.
      frac_r = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
   end

   // ---------------- FSM / next state ----------------
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      x_d      = x_q;
      t_d      = t_q;
      q_d      = q_q;
      sticky_d = sticky_q;
      sp_d     = sp_q;
      sp_inf_d = sp_inf_q;
      d_d      = d_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.a;
               b_d     = bus.b;
               state_d = S_SEED;
            end
         end
         S_SEED: begin
            x_d      = {1'b1, seed, {(FRAC_W - 1 - SEED_W){1'b0}}};
            // Zero/denormal divisor and any inf operand give inf; zero/denormal
            // dividend otherwise gives zero. The datapath still runs to keep latency fixed.
            sp_inf_d = (b_exp == 8'd0) | (a_exp == EXP_INF) | (b_exp == EXP_INF);
            sp_d     = sp_inf_d | (a_exp == 8'd0);
            state_d  = S_NR1M;
         end
         S_NR1M, S_NR2M: begin
            t_d     = prod[63:32];
            state_d = (state_q == S_NR1M) ? S_NR1S : S_NR2S;
         end
         S_NR1S, S_NR2S: begin
            x_d     = prod[62:31];
            state_d = (state_q == S_NR1S) ? S_NR2M : S_QMUL;
         end
         S_QMUL: begin
            q_d     = prod[55:30];
            state_d = S_REM;
         end
         S_REM: begin
            q_d      = q_fix;
            sticky_d = (r_fix != '0);
            state_d  = S_RND;
         end
         S_RND: begin
            if (sp_q) begin
               d_d   = {sign, sp_inf_q ? INF_MAG : ZERO_MAG};
               ovf_d = sp_inf_q;
               unf_d = 1'b0;
            end else if ($signed(e_r) > 10'sd254) begin
               d_d   = {sign, INF_MAG};
               ovf_d = 1'b1;
               unf_d = 1'b0;
            end else if ($signed(e_r) < 10'sd1) begin
               d_d   = {sign, ZERO_MAG};
               ovf_d = 1'b0;
               unf_d = 1'b1;
            end else begin
               d_d   = {sign, e_r[7:0], frac_r};
               ovf_d = 1'b0;
               unf_d = 1'b0;
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            if (bus.out_ready) begin
               ovf_d   = 1'b0;
               unf_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- state registers ----------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         x_q      <= '0;
         t_q      <= '0;
         q_q      <= '0;
         sticky_q <= 1'b0;
         sp_q     <= 1'b0;
         sp_inf_q <= 1'b0;
         d_q      <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         x_q      <= x_d;
         t_q      <= t_d;
         q_q      <= q_d;
         sticky_q <= sticky_d;
         sp_q     <= sp_d;
         sp_inf_q <= sp_inf_d;
         d_q      <= d_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.d         = d_q;
   assign bus.overflow  = ovf_q;
   assign bus.underflow = unf_q;

endmodule

// File: tb/tb_fdiv_iter.sv
// tb/tb_fdiv_iter.sv - self-checking bench for fdiv_iter

module tb_fdiv_iter;

   logic clk = 1'b0;
   logic rstn;

   always #5 clk = ~clk;

   fdiv_iter_if bus ();

   fdiv_iter dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] d;
      logic        ovf;
      logic        unf;
   } vec_t;

   vec_t tbl [17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: exact integer quotient, RNE at 24 bits, then range checks.
   function automatic logic [33:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      logic   s;
      int     ea, eb, e, sh;
      longint am, bm, num, q, r, mant, lower, half;
      bit     up;
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      if (eb == 0)                return {2'b10, s, 31'h7f800000};
      if (ea == 255 || eb == 255) return {2'b10, s, 31'h7f800000};
      if (ea == 0)                return {2'b00, s, 31'h0};
      am  = longint'({1'b1, a[22:0]});
      bm  = longint'({1'b1, b[22:0]});
      num = am * 64'sd67108864;
      q   = num / bm;
      r   = num % bm;
      if (q >= 64'sd67108864) begin
         sh = 3;
         e  = ea - eb + 127;
      end else begin
         sh = 2;
         e  = ea - eb + 126;
      end
      mant  = q >> sh;
      lower = q - (mant << sh);
      half  = (sh == 3) ? 64'sd4 : 64'sd2;
      up    = (lower > half) || ((lower == half) && ((r != 0) || ((mant % 2) == 1)));
      mant  = mant + (up ? 64'sd1 : 64'sd0);
      if (mant == 64'sd16777216) begin
         mant = 64'sd8388608;
         e++;
      end
      if (e > 254) return {2'b10, s, 31'h7f800000};
      if (e < 1)   return {2'b01, s, 31'h0};
      return {2'b00, s, 8'(e), 23'(mant)};
   endfunction

   // Issue one operation and wait for its result; call #1 after a rising edge.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] d, output logic ovf, output logic unf,
                         output int lat);
      int guard;
      guard = 0;
      bus.a = a;
      bus.b = b;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!bus.in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: in_ready stuck low for a=%h b=%h", a, b);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!bus.out_valid) begin
         n_checks++;
         n_fail++;
         $display("FAIL result_timeout: out_valid low after %0d cycles", lat);
      end
      d   = bus.d;
      ovf = bus.overflow;
      unf = bus.underflow;
   endtask

   task automatic release_out(input int delay);
      repeat (delay) begin
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d, d0;
      logic        ovf, unf;
      logic [33:0] exp_r;
      int          lat, bad;

      tbl[0]  = '{32'h3f800000, 32'h40000000, 32'h3f000000, 1'b0, 1'b0};
      tbl[1]  = '{32'h40c00000, 32'h40400000, 32'h40000000, 1'b0, 1'b0};
      tbl[2]  = '{32'h3f800000, 32'h40400000, 32'h3eaaaaab, 1'b0, 1'b0};
      tbl[3]  = '{32'hbf800000, 32'h00000000, 32'hff800000, 1'b1, 1'b0};
      tbl[4]  = '{32'h00000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0};
      tbl[5]  = '{32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 1'b1};
      tbl[6]  = '{32'h7f000000, 32'h3e800000, 32'h7f800000, 1'b1, 1'b0};
      tbl[7]  = '{32'h7f800000, 32'h3f800000, 32'h7f800000, 1'b1, 1'b0};
      tbl[8]  = '{32'h80000000, 32'h3f800000, 32'h80000000, 1'b0, 1'b0};
      tbl[9]  = '{32'h00000000, 32'h00000000, 32'h7f800000, 1'b1, 1'b0};
      tbl[10] = '{32'h3f800000, 32'h3f800001, 32'h3f7ffffe, 1'b0, 1'b0};
      tbl[11] = '{32'hff7fffff, 32'h3f7fffff, 32'hff800000, 1'b1, 1'b0};
      tbl[12] = '{32'h00800000, 32'h3f800000, 32'h00800000, 1'b0, 1'b0};
      tbl[13] = '{32'h00800000, 32'h3f800001, 32'h00000000, 1'b0, 1'b1};
      tbl[14] = '{32'h3f800000, 32'h7f800000, 32'h7f800000, 1'b1, 1'b0};
      tbl[15] = '{32'hc0400000, 32'h3fc00000, 32'hc0000000, 1'b0, 1'b0};
      tbl[16] = '{32'h3f800000, 32'h3f7fffff, 32'h3f800001, 1'b0, 1'b0};

      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b0;
      rstn          = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_d",         bus.d,              32'd0);
      chk("rst_flags",     {30'd0, bus.overflow, bus.underflow}, 32'd0);
      rstn = 1'b1;
      @(posedge clk); #1;

      // Directed vectors
      for (int i = 0; i < 17; i++) begin
         run_op(tbl[i].a, tbl[i].b, d, ovf, unf, lat);
         chk($sformatf("vec%0d_d", i),   d, tbl[i].d);
         chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(tbl[i].ovf));
         chk($sformatf("vec%0d_unf", i), 32'(unf), 32'(tbl[i].unf));
         chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd8);
         release_out(0);
         chk($sformatf("vec%0d_flags_clr", i),
             {29'd0, bus.out_valid, bus.overflow, bus.underflow}, 32'd0);
      end

      // Backpressure: hold result for 20 cycles
      run_op(32'h40c00000, 32'h40400000, d0, ovf, unf, lat);
      chk("bp_d", d0, 32'h40000000);
      bad = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (bus.d !== d0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) bad++;
      end
      chk("bp_hold", 32'(bad), 32'd0);
      release_out(0);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd1);
      run_op(32'h3f800000, 32'h40400000, d, ovf, unf, lat);
      chk("bp_next_d", d, 32'h3eaaaaab);
      chk("bp_next_lat", 32'(lat), 32'd8);
      release_out(0);

      // Reset while in NR2M (third edge after accept)
      bus.a = 32'h40c00000;
      bus.b = 32'h40400000;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("mid_rst_d",         bus.d,              32'd0);
      @(negedge clk);
      rstn = 1'b1;
      bad = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) bad++;
      end
      chk("mid_rst_no_result", 32'(bad), 32'd0);
      run_op(32'h3f800000, 32'h40000000, d, ovf, unf, lat);
      chk("post_rst_d", d, 32'h3f000000);
      chk("post_rst_lat", 32'(lat), 32'd8);
      release_out(0);

      // Random operands against the reference model
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] ra, rb;
         int          sel;
         ra = $urandom;
         rb = $urandom;
         sel = $urandom_range(0, 19);
         if (sel == 0)      ra[30:23] = 8'h00;
         else if (sel == 1) ra[30:23] = 8'hff;
         else               ra[30:23] = 8'($urandom_range(1, 254));
         sel = $urandom_range(0, 19);
         if (sel == 0)      rb[30:23] = 8'h00;
         else if (sel == 1) rb[30:23] = 8'hff;
         else               rb[30:23] = 8'($urandom_range(1, 254));
         exp_r = ref_div(ra, rb);
         run_op(ra, rb, d, ovf, unf, lat);
         chk($sformatf("rnd_d a=%h b=%h", ra, rb), d, exp_r[31:0]);
         chk($sformatf("rnd_flags a=%h b=%h", ra, rb),
             {30'd0, ovf, unf}, {30'd0, exp_r[33], exp_r[32]});
         chk("rnd_lat", 32'(lat), 32'd8);
         release_out($urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
